// File: rtl/i_mem_loader.sv
// Host-to-i_mem program loader: packs bytes little-endian into words, writes them sequentially
// and holds the core in reset until done. Define I_MEM_LOADER_VERIFY_EN for XOR read-back check.
module i_mem_loader #(
  parameter int unsigned I_MEM_SIZE = 32'h800,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        start,
  input  logic [9:0]  length_words,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  output logic        mem_rden,
  output logic        mem_wren,
  input  logic [31:0] mem_q,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        core_hold
);

  localparam int unsigned MaxWords = I_MEM_SIZE / 4;

`ifdef I_MEM_LOADER_VERIFY_EN
  typedef enum logic [2:0] {StIdle, StCollect, StWrite, StDone, StVrd, StVcmp} state_e;
`else
  typedef enum logic [1:0] {StIdle, StCollect, StWrite, StDone} state_e;
`endif

  state_e      state_q;
  logic [9:0]  len_q;
  logic [9:0]  word_idx_q;
  logic [1:0]  byte_cnt_q;
  logic [23:0] lanes_q;

  logic       len_zero;
  logic       len_too_big;
  logic [9:0] word_idx_inc;

  assign len_zero     = (length_words == 10'd0);
  assign len_too_big  = (32'(length_words) > MaxWords);
  assign word_idx_inc = word_idx_q + 10'd1;

  function automatic logic [31:0] word_addr(input logic [9:0] idx);
    return BASE_ADDR + {20'd0, idx, 2'b00};
  endfunction

`ifdef I_MEM_LOADER_VERIFY_EN
  logic [9:0]  rd_idx_q;
  logic [31:0] sum_wr_q;
  logic [31:0] sum_rd_q;
  logic        rd_pend_q;
  logic [31:0] sum_rd_final;
  logic [9:0]  rd_idx_inc;

  // The last read's data arrives during VCMP, so fold it in before comparing.
  assign sum_rd_final = sum_rd_q ^ mem_q;
  assign rd_idx_inc   = rd_idx_q + 10'd1;
`else
  logic unused_mem_q;
  assign unused_mem_q = ^mem_q;
  assign mem_rden     = 1'b0;
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      len_q       <= 10'd0;
      word_idx_q  <= 10'd0;
      byte_cnt_q  <= 2'd0;
      lanes_q     <= 24'd0;
      in_ready    <= 1'b0;
      mem_address <= 32'd0;
      mem_data    <= 32'd0;
      mem_wren    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      core_hold   <= 1'b1;
`ifdef I_MEM_LOADER_VERIFY_EN
      mem_rden    <= 1'b0;
      rd_idx_q    <= 10'd0;
      sum_wr_q    <= 32'd0;
      sum_rd_q    <= 32'd0;
      rd_pend_q   <= 1'b0;
`endif
    end else begin
`ifdef I_MEM_LOADER_VERIFY_EN
      rd_pend_q <= mem_rden;
      if (rd_pend_q) begin
        sum_rd_q <= sum_rd_final;
      end
`endif
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            len_q      <= length_words;
            word_idx_q <= 10'd0;
            byte_cnt_q <= 2'd0;
            error      <= 1'b0;
            done       <= 1'b0;
            core_hold  <= 1'b1;
`ifdef I_MEM_LOADER_VERIFY_EN
            sum_wr_q   <= 32'd0;
            sum_rd_q   <= 32'd0;
            rd_idx_q   <= 10'd0;
`endif
            if (len_zero) begin
              state_q   <= StDone;
              done      <= 1'b1;
              busy      <= 1'b0;
              core_hold <= 1'b0;
            end else if (len_too_big) begin
              state_q <= StDone;
              error   <= 1'b1;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              state_q  <= StCollect;
              busy     <= 1'b1;
              in_ready <= 1'b1;
            end
          end
        end

        StCollect: begin
          if (in_valid && in_ready) begin
            if (byte_cnt_q == 2'd3) begin
              state_q     <= StWrite;
              byte_cnt_q  <= 2'd0;
              in_ready    <= 1'b0;
              mem_wren    <= 1'b1;
              mem_address <= word_addr(word_idx_q);
              mem_data    <= {in_byte, lanes_q};
            end else begin
              byte_cnt_q <= byte_cnt_q + 2'd1;
              case (byte_cnt_q)
                2'd0:    lanes_q[7:0]   <= in_byte;
                2'd1:    lanes_q[15:8]  <= in_byte;
                default: lanes_q[23:16] <= in_byte;
              endcase
            end
          end
        end

        StWrite: begin
          mem_wren    <= 1'b0;
          mem_address <= 32'd0;
          mem_data    <= 32'd0;
          word_idx_q  <= word_idx_inc;
`ifdef I_MEM_LOADER_VERIFY_EN
          sum_wr_q    <= sum_wr_q ^ mem_data;
`endif
          if (word_idx_inc < len_q) begin
            state_q  <= StCollect;
            in_ready <= 1'b1;
          end else begin
`ifdef I_MEM_LOADER_VERIFY_EN
            state_q     <= StVrd;
            rd_idx_q    <= 10'd0;
            mem_rden    <= 1'b1;
            mem_address <= word_addr(10'd0);
`else
            state_q   <= StDone;
            busy      <= 1'b0;
            done      <= 1'b1;
            core_hold <= 1'b0;
`endif
          end
        end

`ifdef I_MEM_LOADER_VERIFY_EN
        StVrd: begin
          if (rd_idx_inc < len_q) begin
            rd_idx_q    <= rd_idx_inc;
            mem_address <= word_addr(rd_idx_inc);
          end else begin
            state_q     <= StVcmp;
            mem_rden    <= 1'b0;
            mem_address <= 32'd0;
          end
        end

        StVcmp: begin
          state_q   <= StDone;
          busy      <= 1'b0;
          done      <= 1'b1;
          error     <= (sum_rd_final != sum_wr_q);
          core_hold <= (sum_rd_final != sum_wr_q);
        end
`endif

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_i_mem_loader.sv
// Randomized self-checking bench for i_mem_loader with a transaction-level model of the loader
// and a behavioural i_mem; honours I_MEM_LOADER_VERIFY_EN like the design.
module tb_i_mem_loader;

  logic        clock;
  logic        rst_n;
  logic        start;
  logic [9:0]  length_words;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic [31:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_rden;
  logic        mem_wren;
  logic [31:0] mem_q;
  logic        busy;
  logic        done;
  logic        error;
  logic        core_hold;

  i_mem_loader dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .start        (start),
    .length_words (length_words),
    .in_valid     (in_valid),
    .in_byte      (in_byte),
    .in_ready     (in_ready),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_rden     (mem_rden),
    .mem_wren     (mem_wren),
    .mem_q        (mem_q),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .core_hold    (core_hold)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural i_mem: synchronous read, optional bit-0 corruption of read data.
  logic [31:0] mem_arr [0:511];
  logic [31:0] q_reg = 32'd0;
  logic        corrupt = 1'b0;
  int          wr_pulses = 0;

  always @(posedge clock) begin
    if (mem_wren) begin
      mem_arr[mem_address[10:2]] <= mem_data;
      wr_pulses <= wr_pulses + 1;
    end
    if (mem_rden) q_reg <= mem_arr[mem_address[10:2]];
  end
  assign mem_q = q_reg ^ {31'd0, corrupt};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Transaction-level model: byte counts, pending write/read/compare events, level outputs.
  bit          m_busy = 0, m_done = 0, m_err = 0, m_hold = 1;
  int          m_len = 0, n_bytes = 0, rd_k = 0;
  bit          wr_now = 0, rd_now = 0, cmp_now = 0;
  logic [31:0] wr_addr = 0, wr_data = 0, cur_word = 0, sum_w = 0, sum_r = 0;
  logic [31:0] img [0:511];

  initial begin
    bit          exp_rdy, wr_next, rd_next, cmp_next;
    logic [31:0] exp_addr;
    forever begin
      @(negedge clock);
      if (!rst_n) begin
        m_busy = 0; m_done = 0; m_err = 0; m_hold = 1;
        m_len = 0; n_bytes = 0; wr_now = 0; rd_now = 0; cmp_now = 0;
      end
      exp_rdy  = m_busy && (n_bytes < 4 * m_len) && !wr_now;
      exp_addr = wr_now ? wr_addr : (rd_now ? 32'(4 * rd_k) : 32'd0);
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("error", 32'(error), 32'(m_err));
      chk("core_hold", 32'(core_hold), 32'(m_hold));
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("mem_wren", 32'(mem_wren), 32'(wr_now));
      chk("mem_rden", 32'(mem_rden), 32'(rd_now));
      chk("mem_address", mem_address, exp_addr);
      chk("mem_data", mem_data, wr_now ? wr_data : 32'd0);
      if (rst_n) begin
        wr_next = 0; rd_next = 0; cmp_next = 0;
        if (start && !m_busy) begin
          m_done = 0; m_err = 0;
          if (length_words == 10'd0) begin
            m_done = 1; m_hold = 0;
          end else if (int'(length_words) > 512) begin
            m_err = 1; m_done = 1; m_hold = 1;
          end else begin
            m_busy = 1; m_hold = 1; m_len = int'(length_words);
            n_bytes = 0; sum_w = 0; sum_r = 0;
          end
        end else begin
          if (in_valid && exp_rdy) begin
            cur_word[8*(n_bytes%4) +: 8] = in_byte;
            n_bytes++;
            if (n_bytes % 4 == 0) begin
              wr_next = 1;
              wr_addr = 32'(4 * (n_bytes / 4 - 1));
              wr_data = cur_word;
              img[n_bytes/4-1] = cur_word;
              sum_w = sum_w ^ cur_word;
            end
          end
          if (wr_now && n_bytes == 4 * m_len) begin
`ifdef I_MEM_LOADER_VERIFY_EN
            rd_next = 1; rd_k = 0;
`else
            m_busy = 0; m_done = 1; m_hold = 0;
`endif
          end
          if (rd_now) begin
            sum_r = sum_r ^ img[rd_k] ^ {31'd0, corrupt};
            if (rd_k + 1 < m_len) begin
              rd_next = 1; rd_k++;
            end else begin
              cmp_next = 1;
            end
          end
          if (cmp_now) begin
            m_busy = 0; m_done = 1; m_err = (sum_r != sum_w); m_hold = m_err;
          end
        end
        wr_now = wr_next; rd_now = rd_next; cmp_now = cmp_next;
      end
    end
  end

  logic [7:0] stim [0:63];

  task automatic do_start(input int len);
    start = 1'b1;
    length_words = 10'(len);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Feeds stim[0..n-1] with random valid gaps and stray start pulses that must be ignored.
  task automatic send_bytes(input int n);
    bit acc;
    int guard;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      in_byte = stim[i];
      forever begin
        in_valid = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 15) == 0);
        length_words = 10'($urandom);
        @(negedge clock);
        acc = in_valid && in_ready;
        @(posedge clock); #1;
        start = 1'b0;
        if (acc) break;
        guard++;
        if (guard > 100) begin
          in_valid = 1'b0;
          timeout("byte_accept");
          return;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    bit seen;
    seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clock);
      if (done) seen = 1;
      @(posedge clock); #1;
      in_valid = 1'(($urandom_range(0, 1)));
      in_byte  = 8'($urandom);
    end
    in_valid = 1'b0;
    if (!seen) timeout("wait_done");
  endtask

  initial begin
    int n0, len, sel;
    rst_n = 1'b0; start = 1'b0; length_words = 10'd0; in_valid = 1'b0; in_byte = 8'd0;
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    chk("rst_core_hold", 32'(core_hold), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_mem_wren", 32'(mem_wren), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clock); #1;
    rst_n = 1'b1;
    @(posedge clock); #1;

    // Two-word load.
    stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33; stim[3] = 8'h44;
    stim[4] = 8'h55; stim[5] = 8'h66; stim[6] = 8'h77; stim[7] = 8'h88;
    do_start(2);
    send_bytes(8);
    wait_done(200);
    @(negedge clock);
    chk("word0", mem_arr[0], 32'h44332211);
    chk("word1", mem_arr[1], 32'h88776655);
    chk("len2_done", 32'(done), 32'd1);
    chk("len2_core_hold", 32'(core_hold), 32'd0);
    @(posedge clock); #1;

    // Zero length: done on the next cycle, no writes.
    n0 = wr_pulses;
    do_start(0);
    @(negedge clock);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_core_hold", 32'(core_hold), 32'd0);
    @(posedge clock); #1;
    repeat (3) @(posedge clock);
    #1;
    chk("len0_no_write", 32'(wr_pulses), 32'(n0));

    // Oversize length.
    do_start(513);
    @(negedge clock);
    chk("big_error", 32'(error), 32'd1);
    chk("big_done", 32'(done), 32'd1);
    chk("big_core_hold", 32'(core_hold), 32'd1);
    @(posedge clock); #1;
    repeat (5) @(posedge clock);
    #1;
    chk("big_no_write", 32'(wr_pulses), 32'(n0));

    // Reset mid-word, then a clean reload.
    stim[0] = 8'hEF; stim[1] = 8'hBE; stim[2] = 8'hAD; stim[3] = 8'hDE;
    do_start(1);
    send_bytes(2);
    rst_n = 1'b0;
    @(posedge clock); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    chk("abort_no_write", 32'(wr_pulses), 32'(n0));
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_core_hold", 32'(core_hold), 32'd1);
    @(posedge clock); #1;
    do_start(1);
    send_bytes(4);
    wait_done(200);
    @(negedge clock);
    chk("reload_word", mem_arr[0], 32'hDEADBEEF);
    chk("reload_core_hold", 32'(core_hold), 32'd0);
    @(posedge clock); #1;

`ifdef I_MEM_LOADER_VERIFY_EN
    // Read-back with and without corrupted read data.
    corrupt = 1'b1;
    do_start(1);
    send_bytes(4);
    wait_done(200);
    @(negedge clock);
    chk("vfy_bad_error", 32'(error), 32'd1);
    chk("vfy_bad_core_hold", 32'(core_hold), 32'd1);
    @(posedge clock); #1;
    corrupt = 1'b0;
    do_start(1);
    send_bytes(4);
    wait_done(200);
    @(negedge clock);
    chk("vfy_ok_error", 32'(error), 32'd0);
    chk("vfy_ok_core_hold", 32'(core_hold), 32'd0);
    @(posedge clock); #1;
`endif

    // Randomized loads.
    for (int r = 0; r < 25; r++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0) len = 0;
      else if (sel == 1) len = int'($urandom_range(513, 1023));
      else len = int'($urandom_range(1, 6));
`ifdef I_MEM_LOADER_VERIFY_EN
      corrupt = 1'(($urandom_range(0, 1)));
`endif
      for (int i = 0; i < 4 * len && i < 64; i++) stim[i] = 8'($urandom);
      do_start(len);
      if (len >= 1 && len <= 512) begin
        send_bytes(4 * len);
        wait_done(300);
        for (int k = 0; k < len; k++) begin
          chk("rand_image", mem_arr[k], {stim[4*k+3], stim[4*k+2], stim[4*k+1], stim[4*k]});
        end
      end else begin
        repeat (2) @(posedge clock);
        #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
